// File: rtl/chnl_rx_dispatch_if.sv
// ---------------------------------------------------------------------------
// chnl_rx_dispatch_if
// Stream bundle between the upstream channel receiver, the dispatcher and
// its sinks.
//   i_val / i_rdy / i_data : upstream word handshake (header + payload words)
//   o_val / o_rdy          : per-sink valid / ready, one bit per sink
//   o_data / o_last        : payload word shared by all sinks, end-of-packet
// Modports:
//   slave  : dispatcher side
//   master : environment side (upstream source and sinks)
// ---------------------------------------------------------------------------
interface chnl_rx_dispatch_if #(
   parameter int WIDTH  = 32,
   parameter int N_DEST = 4
);
   logic              i_val;
   logic              i_rdy;
   logic [WIDTH-1:0]  i_data;
   logic [N_DEST-1:0] o_val;
   logic [N_DEST-1:0] o_rdy;
   logic [WIDTH-1:0]  o_data;
   logic              o_last;

   modport slave (
      input  i_val, i_data, o_rdy,
      output i_rdy, o_val, o_data, o_last
   );

   modport master (
      output i_val, i_data, o_rdy,
      input  i_rdy, o_val, o_data, o_last
   );
endinterface

// File: rtl/chnl_rx_dispatch.sv
// ---------------------------------------------------------------------------
// chnl_rx_dispatch
// Splits an upstream word stream into packets (one header word followed by
// L payload words) and forwards each payload word to the sink selected in
// the header. Packets addressed to a non-existent sink are consumed and
// discarded. Payload forwarding is a zero-cycle combinational pass-through.
//   Header: dest = i_data[31:24], L = i_data[23:0]; bits above 31 ignored.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : chnl_rx_dispatch_if.slave (upstream handshake + sink ports)
//   busy     : high while a packet payload is being forwarded or dropped
//   drop_cnt : number of dropped packets (saturating)
// Build option:
//   CHNL_RX_DISPATCH_DROP_CNT_EN : builds the drop counter; otherwise
//                                  drop_cnt is tied to zero.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_HEADER  | waiting for a header word; header is consumed, not forwarded
// S_FORWARD | passing payload words through to sink dest_q
// S_DROP    | consuming and discarding payload of an unroutable packet
// ---------------------------------------------------------------------------
module chnl_rx_dispatch #(
   parameter int WIDTH  = 32,
   parameter int N_DEST = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   chnl_rx_dispatch_if.slave        bus,
   output logic                     busy,
   output logic [15:0]              drop_cnt
);

   typedef enum logic [1:0] {
      S_HEADER  = 2'd0,
      S_FORWARD = 2'd1,
      S_DROP    = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [23:0]       cnt_left;
   logic [7:0]        dest_q;

   logic [7:0]        hdr_dest;
   logic [23:0]       hdr_len;
   logic              hdr_len_zero;
   logic              hdr_dest_ok;
   logic              accept;
   logic              cnt_last;
   logic              hdr_accept;
   logic [N_DEST-1:0] rdy_shift;
   logic              rdy_sel;

   assign hdr_dest     = bus.i_data[31:24];
   assign hdr_len      = bus.i_data[23:0];
   assign hdr_len_zero = (hdr_len == 24'd0);
   // 9-bit compare so that N_DEST = 256 accepts every 8-bit dest
   assign hdr_dest_ok  = ({1'b0, hdr_dest} < 9'(N_DEST));
   assign accept       = bus.i_val & bus.i_rdy;
   assign hdr_accept   = (state == S_HEADER) & accept;
   assign cnt_last     = (cnt_left == 24'd1);

   // shift instead of indexing so dest_q width need not match log2(N_DEST)
   assign rdy_shift    = bus.o_rdy >> dest_q;
   assign rdy_sel      = rdy_shift[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_HEADER;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_HEADER: begin
            if (accept && !hdr_len_zero) begin
               state_nxt = hdr_dest_ok ? S_FORWARD : S_DROP;
            end
         end
         S_FORWARD, S_DROP: begin
            if (accept && cnt_last) begin
               state_nxt = S_HEADER;
            end
         end
         default: state_nxt = S_HEADER;
      endcase
   end

   always_comb begin
      bus.i_rdy  = 1'b1;
      bus.o_val  = '0;
      bus.o_data = bus.i_data;
      bus.o_last = 1'b0;
      busy       = 1'b0;
      case (state)
         S_FORWARD: begin
            // i_rdy follows only the selected sink ready, never i_val
            bus.i_rdy  = rdy_sel;
            bus.o_val  = N_DEST'(bus.i_val) << dest_q;
            bus.o_last = cnt_last;
            busy       = 1'b1;
         end
         S_DROP: begin
            busy       = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_left <= 24'd0;
         dest_q   <= 8'd0;
      end else if (hdr_accept) begin
         cnt_left <= hdr_len;
         dest_q   <= hdr_dest;
      end else if (accept && (state != S_HEADER)) begin
         cnt_left <= cnt_left - 24'd1;
      end
   end

`ifdef CHNL_RX_DISPATCH_DROP_CNT_EN
   logic [15:0] drop_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= 16'd0;
      end else if (hdr_accept && !hdr_len_zero && !hdr_dest_ok &&
                   (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_chnl_rx_dispatch.sv
module tb_chnl_rx_dispatch;
   localparam int WIDTH  = 32;
   localparam int N_DEST = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        busy;
   logic [15:0] drop_cnt;
   int          cyc = 0;

   chnl_rx_dispatch_if #(.WIDTH(WIDTH), .N_DEST(N_DEST)) bus ();

   chnl_rx_dispatch #(.WIDTH(WIDTH), .N_DEST(N_DEST)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .busy     (busy),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int               dest;
      logic [WIDTH-1:0] data;
      bit               last;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   exp_drops = 0;
   int   rdy_mode  = 0;   // 0 random, 1 all ready, 2 fixed, 3 bit0 toggling
   logic [N_DEST-1:0] rdy_fix = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] drop_expect();
`ifdef CHNL_RX_DISPATCH_DROP_CNT_EN
      return 16'(exp_drops);
`else
      return 16'd0;
`endif
   endfunction

   // sink ready generator
   initial begin
      bit tog = 1'b0;
      bus.o_rdy = '0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1: bus.o_rdy = '1;
            2: bus.o_rdy = rdy_fix;
            3: begin
               bus.o_rdy    = N_DEST'($urandom);
               bus.o_rdy[0] = tog;
               tog          = ~tog;
            end
            default: bus.o_rdy = N_DEST'($urandom);
         endcase
      end
   end

   // scoreboard monitor: every sink transfer must match the head of exp_q
   initial begin
      exp_t e;
      logic [N_DEST-1:0] ev;
      forever begin
         @(negedge clk);
         if (rst_n && ((bus.o_val & bus.o_rdy) != '0)) begin
            chk("o_val_onehot", 64'($onehot0(bus.o_val)), 64'd1);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_out: o_val=%b o_data=0x%0h o_last=%0b", bus.o_val, bus.o_data, bus.o_last);
            end else begin
               e = exp_q.pop_front();
               ev = '0;
               ev[e.dest] = 1'b1;
               chk("o_val", 64'(bus.o_val), 64'(ev));
               chk("o_data", 64'(bus.o_data), 64'(e.data));
               chk("o_last", 64'(bus.o_last), 64'(e.last));
            end
         end
      end
   end

   task automatic send_word(input logic [WIDTH-1:0] d, output int acc);
      int n = 0;
      bus.i_val  = 1'b1;
      bus.i_data = d;
      forever begin
         @(negedge clk);
         if (bus.i_rdy) break;
         n++;
         if (n > 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: word 0x%0h not accepted after %0d cycles", d, n);
            break;
         end
      end
      @(posedge clk);
      #1;
      acc = cyc;
   endtask

   task automatic send_pkt(input int dest, input int len, input bit gaps, input bit hold,
                           output int hdr_acc, output int last_acc);
      logic [WIDTH-1:0] hdr;
      logic [WIDTH-1:0] words[$];
      hdr = WIDTH'($urandom);
      hdr[31:24] = dest[7:0];
      hdr[23:0]  = len[23:0];
      for (int i = 0; i < len; i++) words.push_back(WIDTH'($urandom));
      if (len > 0) begin
         if (dest < N_DEST) begin
            for (int i = 0; i < len; i++)
               exp_q.push_back('{dest: dest, data: words[i], last: (i == len - 1)});
         end else if (exp_drops < 65535) begin
            exp_drops++;
         end
      end
      send_word(hdr, hdr_acc);
      chk("busy_after_hdr", 64'(busy), 64'(len > 0));
      last_acc = hdr_acc;
      for (int i = 0; i < len; i++) begin
         send_word(words[i], last_acc);
         if (gaps && (i < len - 1) && ($urandom_range(0, 3) == 0)) begin
            bus.i_val = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      if (len > 0) chk("busy_after_pkt", 64'(busy), 64'd0);
      if (!hold) bus.i_val = 1'b0;
   endtask

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      int h, l, d, len, acc;
      logic [WIDTH-1:0] w;
      rst_n      = 1'b0;
      bus.i_val  = 1'b0;
      bus.i_data = '0;

      repeat (2) @(negedge clk);
      chk("rst_o_val", 64'(bus.o_val), 64'd0);
      chk("rst_o_last", 64'(bus.o_last), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_i_rdy", 64'(bus.i_rdy), 64'd1);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // single packet to sink 1, sink 1 always ready
      rdy_mode = 2;
      rdy_fix  = 4'b0010;
      send_pkt(1, 3, 1'b0, 1'b0, h, l);

      // sink 0 ready toggling, other ready bits random
      rdy_mode = 3;
      send_pkt(0, 2, 1'b0, 1'b0, h, l);

      // unroutable destination
      rdy_mode = 0;
      send_pkt(7, 2, 1'b0, 1'b0, h, l);
      chk("drop_cnt_one", 64'(drop_cnt), 64'(drop_expect()));

      // zero-length packet then a single-word packet to sink 3
      send_pkt(2, 0, 1'b0, 1'b0, h, l);
      send_pkt(3, 1, 1'b0, 1'b0, h, l);

      // back-to-back packets with i_val held high
      rdy_mode = 1;
      send_pkt(0, 2, 1'b0, 1'b1, h, l);
      acc = l;
      send_pkt(1, 1, 1'b0, 1'b0, h, l);
      chk("b2b_hdr_cycle", 64'(h), 64'(acc + 1));

      // randomized traffic
      rdy_mode = 0;
      for (int p = 0; p < 40; p++) begin
         d   = ($urandom_range(0, 7) == 0) ? 200 : int'($urandom_range(0, 5));
         len = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 5));
         send_pkt(d, len, 1'b1, 1'b0, h, l);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
      end
      chk("drop_cnt_random", 64'(drop_cnt), 64'(drop_expect()));

      // reset in the middle of a packet
      rdy_mode = 1;
      w = 32'h0100_0003;
      for (int i = 0; i < 3; i++) exp_q.push_back('{dest: 1, data: WIDTH'(32'hA000_0000 + i), last: (i == 2)});
      send_word(w, acc);
      send_word(WIDTH'(32'hA000_0000), acc);
      bus.i_val = 1'b0;
      rst_n     = 1'b0;
      exp_q.delete();
      exp_drops = 0;
      @(negedge clk);
      chk("midrst_o_val", 64'(bus.o_val), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_i_rdy", 64'(bus.i_rdy), 64'd1);
      chk("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_pkt(2, 1, 1'b0, 1'b0, h, l);

      repeat (5) @(posedge clk);
      #1;
      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/chnl_rx_dispatch.md
CHNL_RX_DISPATCH -- requirements
Module: chnl_rx_dispatch

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning stream word width in bits (WIDTH >= 32).
REQ-002 SHALL have parameter N_DEST, default 4, meaning number of sink ports (1..256).
REQ-003 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_val  input  1  upstream word valid (from chnl_rx o_val).
REQ-006 SHALL have port i_rdy  output  1  upstream word accepted when i_val && i_rdy.
REQ-007 SHALL have port i_data  input  WIDTH  upstream word.
REQ-008 SHALL have port o_val  output  N_DEST  per-sink valid, at most one bit set.
REQ-009 SHALL have port o_rdy  input  N_DEST  per-sink ready.
REQ-010 SHALL have port o_data  output  WIDTH  payload word shared by all sinks.
REQ-011 SHALL have port o_last  output  1  marks the final payload word of a packet.
REQ-012 SHALL have port busy  output  1  high while a packet is being forwarded or dropped.
REQ-013 SHALL have port drop_cnt  output  16  count of dropped packets.

Function
REQ-014 SHALL parse packets of the form: one header word, then L payload words.
REQ-015 Header fields SHALL be dest = i_data[31:24] and L = i_data[23:0]; bits above 31 SHALL be ignored.
REQ-016 SHALL implement states S_HEADER, S_FORWARD and S_DROP.
REQ-017 In S_HEADER: i_rdy = 1, o_val = 0, busy = 0; the header is consumed and not forwarded.
REQ-018 On header accept: L == 0 -> stay in S_HEADER; dest < N_DEST -> S_FORWARD; otherwise -> S_DROP; cnt_left <= L and dest is latched.
REQ-019 In S_FORWARD: o_val[dest] = i_val, other bits 0, o_data = i_data, i_rdy = o_rdy[dest]; zero-cycle combinational pass-through.
REQ-020 In S_DROP: i_rdy = 1, o_val = 0; accepted words are discarded.
REQ-021 In S_FORWARD and S_DROP, each accepted word SHALL decrement cnt_left (24-bit); when cnt_left == 1 at accept, the next state SHALL be S_HEADER.
REQ-022 o_last SHALL be 1 exactly when in S_FORWARD and cnt_left == 1.
REQ-023 o_rdy bits of non-selected sinks SHALL be ignored; i_rdy SHALL NOT depend on i_val (no combinational loop).
REQ-024 The next header SHALL be accepted no earlier than the cycle after the last payload word (back-to-back packets, no bubble beyond that).
REQ-025 busy SHALL be 1 in S_FORWARD and S_DROP.

Reset
REQ-026 While rst_n = 0: state = S_HEADER, cnt_left = 0, latched dest = 0, drop_cnt = 0; outputs o_val = 0, o_last = 0, busy = 0, i_rdy = 1.
REQ-027 Reset asserted mid-packet SHALL abort the packet immediately; after release, the next accepted word SHALL be treated as a header.

Configuration
REQ-028 With macro CHNL_RX_DISPATCH_DROP_CNT_EN defined, drop_cnt SHALL increment by 1 on each header accept that enters S_DROP, saturating at 16'hFFFF.
REQ-029 Without CHNL_RX_DISPATCH_DROP_CNT_EN, drop_cnt SHALL be constant 0 and no counter register SHALL be built.

Verification
REQ-030 Header 0x01000003 then words A, B, C with o_rdy = 4'b0010 -> o_val = 4'b0010 for 3 accepts, data A/B/C, o_last only on C, then S_HEADER.
REQ-031 Header 0x00000002, then 2 words with o_rdy[0] toggling 1/0 each cycle -> i_rdy follows o_rdy[0], exactly 2 transfers, no word lost or duplicated.
REQ-032 Header 0x07000002 with N_DEST = 4 -> both payload words consumed with o_val = 0; drop_cnt = 1 with macro defined, 0 without.
REQ-033 Header 0x02000000 followed by header 0x03000001 and word D -> first packet emits nothing; D appears on o_val[3] with o_last = 1.
REQ-034 rst_n pulsed low after 1 of 3 payload words -> o_val = 0 and busy = 0 during reset; the next word after release is parsed as a header.
REQ-035 Back-to-back packets to dest 0 and dest 1 with i_val held high -> the second header is accepted the cycle after the first o_last transfer.
